// File: rtl/dmem_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port data memory.
// Optional power-on scrub of every word is compiled in with `define DMEM_SCRUB_EN.
module dmem_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic              WE,
    output logic [ADDR_W-1:0] A_DM,
    output logic [DATA_W-1:0] WD,
    input  logic [DATA_W-1:0] RD3,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_SERVE = 2'd1,
        ST_SCRUB = 2'd2
    } state_t;

`ifdef DMEM_SCRUB_EN
    localparam int     CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam state_t RESET_ST = ST_SCRUB;
    logic [CNT_W-1:0] r_cnt;
`else
    localparam state_t RESET_ST = ST_ARB;
`endif

    state_t              r_state;
    state_t              w_next;
    logic                r_ptr;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_accept;
    logic                w_inrange;

    logic                r_owner_p0;
    logic                r_we_p0;
    logic [ADDR_W-1:0]   r_addr_p0;
    logic [DATA_W-1:0]   r_wdata_p0;

    logic [1:0]              r_rvalid;
    logic [1:0]              r_err;
    logic [1:0][DATA_W-1:0]  r_rdata;

    assign w_accept  = (r_state == ST_ARB) && (r0_req || r1_req);
    assign w_inrange = (r_addr_p0 < ADDR_W'(DEPTH));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= RESET_ST;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ARB:   if (r0_req || r1_req) w_next = ST_SERVE;
            ST_SERVE: w_next = ST_ARB;
`ifdef DMEM_SCRUB_EN
            ST_SCRUB: if (r_cnt == CNT_W'(DEPTH - 1)) w_next = ST_ARB;
`endif
            default:  w_next = ST_ARB;
        endcase
    end

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        WE     = 1'b0;
        A_DM   = '0;
        WD     = '0;
        busy   = 1'b0;
        case (r_state)
            ST_ARB: begin
                // r_ptr=0 favours requester 0 when both ask in the same cycle
                w_gnt0 = r0_req && (!r1_req || !r_ptr);
                w_gnt1 = r1_req && (!r0_req ||  r_ptr);
            end
            ST_SERVE: begin
                busy = 1'b1;
                WE   = r_we_p0 && w_inrange;
                A_DM = r_addr_p0;
                WD   = r_wdata_p0;
            end
`ifdef DMEM_SCRUB_EN
            ST_SCRUB: begin
                busy = 1'b1;
                WE   = 1'b1;
                A_DM = ADDR_W'(r_cnt);
            end
`endif
            default: ;
        endcase
    end

    assign r0_gnt = w_gnt0;
    assign r1_gnt = w_gnt1;

    // ---- stage p0: transaction accepted in ARB, held for the SERVE cycle ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ptr      <= 1'b0;
            r_owner_p0 <= 1'b0;
            r_we_p0    <= 1'b0;
        end else if (w_accept) begin
            r_ptr      <= !w_gnt1;
            r_owner_p0 <= w_gnt1;
            r_we_p0    <= w_gnt1 ? r1_we : r0_we;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_addr_p0  <= w_gnt1 ? r1_addr : r0_addr;
            r_wdata_p0 <= w_gnt1 ? r1_wdata : r0_wdata;
        end
    end

`ifdef DMEM_SCRUB_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (r_state == ST_SCRUB) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`endif

    // ---- stage p1: response registered at the end of SERVE ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= '0;
            r_err    <= '0;
            if (r_state == ST_SERVE) begin
                r_rvalid[r_owner_p0] <= 1'b1;
                r_err[r_owner_p0]    <= !w_inrange;
                r_rdata[r_owner_p0]  <= (!r_we_p0 && w_inrange) ? RD3 : '0;
            end
        end
    end

    assign r0_rvalid = r_rvalid[0];
    assign r1_rvalid = r_rvalid[1];
    assign r0_err    = r_err[0];
    assign r1_err    = r_err[1];
    assign r0_rdata  = r_rdata[0];
    assign r1_rdata  = r_rdata[1];

endmodule
